// File: rtl/chunked_add_seq_if.sv
// chunked_add_seq_if
//   Requester <-> chunked adder handshake and operand/result bus.
//   Parameters SIZE/WORDS must match the attached chunked_add_seq.
//   Signals:
//     start  : request, accepted only while busy=0
//     A, B   : W-bit operands, sampled at acceptance
//     cin    : carry-in, sampled at acceptance
//     sub    : subtract request (only with CHUNKED_ADD_SUB_EN defined)
//     busy   : operation in progress
//     done   : one-cycle completion pulse
//     Sum    : result of the last completed operation
//     cout   : carry-out of the last completed operation
//   Optional feature macro: CHUNKED_ADD_SUB_EN
interface chunked_add_seq_if #(
   parameter int unsigned SIZE  = 4,
   parameter int unsigned WORDS = 4
);
   localparam int unsigned W = SIZE * WORDS;

   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         cin;
`ifdef CHUNKED_ADD_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] Sum;
   logic         cout;

`ifdef CHUNKED_ADD_SUB_EN
   modport master (output start, A, B, cin, sub, input busy, done, Sum, cout);
   modport slave  (input start, A, B, cin, sub, output busy, done, Sum, cout);
`else
   modport master (output start, A, B, cin, input busy, done, Sum, cout);
   modport slave  (input start, A, B, cin, output busy, done, Sum, cout);
`endif
endinterface

// File: rtl/chunked_add_seq.sv
// chunked_add_seq
//   Multi-cycle wide adder: adds two SIZE*WORDS-bit operands by time-sharing
//   one SIZE-bit ripple slice (full-adder cells) over WORDS cycles, low chunk
//   first, carrying between chunks through a register.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : chunked_add_seq_if slave (start/A/B/cin[/sub] in,
//             busy/done/Sum/cout out)
//   Optional feature macro: CHUNKED_ADD_SUB_EN adds a sub input; sub=1
//   computes A-B (B inverted chunkwise, initial carry forced to 1, cin
//   ignored), cout=1 meaning no borrow.
module chunked_add_seq #(
   parameter int unsigned SIZE  = 4,
   parameter int unsigned WORDS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   chunked_add_seq_if.slave  bus
);
   localparam int unsigned W     = SIZE * WORDS;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                     state_q, state_d;
   logic [WORDS-1:0][SIZE-1:0] a_q, b_q, work_q, work_d;
   logic [IDX_W-1:0]           idx_q;
   logic                       carry_q;
   logic [W-1:0]               sum_q;
   logic                       cout_q;
   logic                       done_q;
   logic                       accept;
   logic                       last;
   logic                       sub_q;
   logic                       sub_in;
   logic [SIZE-1:0]            op_a, op_b, slice_sum;
   logic [SIZE:0]              rc;

`ifdef CHUNKED_ADD_SUB_EN
   assign sub_in = bus.sub;
`else
   assign sub_in = 1'b0;
`endif

   // Shared slice: ripple chain of full-adder cells fed by the current chunk.
   always_comb begin
      op_a      = a_q[idx_q];
      op_b      = b_q[idx_q] ^ {SIZE{sub_q}};
      rc        = '0;
      slice_sum = '0;
      rc[0]     = carry_q;
      for (int unsigned i = 0; i < SIZE; i++) begin
         slice_sum[i] = op_a[i] ^ op_b[i] ^ rc[i];
         rc[i+1]      = (op_a[i] & op_b[i]) | (rc[i] & (op_a[i] ^ op_b[i]));
      end
   end

   // Work result with the current chunk merged in, so the final chunk is
   // already present when Sum is loaded on the last RUN edge.
   always_comb begin
      work_d        = work_q;
      work_d[idx_q] = slice_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (idx_q == LAST_IDX) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= last;
         if (accept) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            work_q  <= '0;
            idx_q   <= '0;
            sub_q   <= sub_in;
            carry_q <= sub_in ? 1'b1 : bus.cin;
         end else if (state_q == RUN) begin
            work_q  <= work_d;
            carry_q <= rc[SIZE];
            if (last) begin
               sum_q  <= work_d;
               cout_q <= rc[SIZE];
            end else begin
               idx_q <= idx_q + 1'b1;
            end
         end
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = done_q;
   assign bus.Sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: doc/chunked_add_seq.md
Name: chunked_add_seq

Overview:
- Multi-cycle wide adder controller. Adds two WORDS*SIZE-bit operands by time-sharing one SIZE-bit ripple adder slice, built from the team's full_adder cell, over WORDS consecutive cycles.
- Sequences chunk selection, carry propagation between chunks and result assembly.
- Sits between a requester (start/busy/done handshake) and wide-arithmetic consumers that cannot afford a full-width ripple chain.

Parameters:
- SIZE, 4, width of the shared adder slice in bits (>=1).
- WORDS, 4, number of SIZE-bit chunks per operand (>=1); total width W = SIZE*WORDS.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when busy=0.
- A  input  W  operand A, sampled at acceptance.
- B  input  W  operand B, sampled at acceptance.
- cin  input  1  carry-in to chunk 0, sampled at acceptance.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when Sum/cout are updated.
- Sum  output  W  result of the last completed operation.
- cout  output  1  carry-out of the last completed operation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, Sum=0, cout=0; chunk index, carry and operand registers cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at a clock edge latches A, B and cin into the carry register, sets idx=0, moves to RUN. busy=1 from the next cycle.
- RUN: each edge feeds A[idx], B[idx] (SIZE-bit chunks, chunk 0 = LSBs) and the carry register into the slice. Slice sum is written into work-result chunk idx; slice carry-out goes into the carry register; idx increments.
- Leaving RUN: after the edge processing idx=WORDS-1, go to DONE. On that same edge load Sum from the work result (including the final chunk), load cout from the final carry, and assert done=1 for exactly one cycle.
- DONE: busy=0. start=1 here is accepted exactly as in IDLE (back-to-back; next state RUN). Otherwise next state is IDLE.
- Latency: start edge -> done high after WORDS+1 edges. Throughput is one operation per WORDS+1 cycles.
- start while busy=1: ignored, no queuing; latched operands are unaffected.
- Sum/cout hold their value until the next completion. They do not change during RUN.
- WORDS=1: a single RUN cycle, which is legal.
- Arithmetic is modulo 2^W. cout is the true carry of A+B+cin.
- Reset mid-RUN: immediate abort to reset values; no done pulse.
- idx width = max(1, clog2(WORDS)); idx never exceeds WORDS-1.

Optional Feature:
- Macro CHUNKED_ADD_SUB_EN.
- Defined: extra input port sub (1 bit), sampled at acceptance. When sub=1:
  - B is inverted chunkwise before the slice.
  - Initial carry is forced to 1 and cin is ignored.
  - Result is A-B modulo 2^W; cout=1 means no borrow.
- Undefined: no sub port; add only, as above.

Test Plan (SIZE=4, WORDS=4):
- A=0x1234, B=0x0FFF, cin=0, start pulse -> busy for 4 cycles; done on the 5th edge after start; Sum=0x2233, cout=0.
- A=0xFFFF, B=0x0001, cin=0 -> Sum=0x0000, cout=1. Carry rippling through all chunks is checked.
- A=0x0000, B=0xFFFF, cin=1 -> Sum=0x0000, cout=1. Separately, start held high continuously -> operations every 5 cycles, back-to-back acceptance in DONE.
- Start with A=0x0001, B=0x0001; pulse start again with A=0xAAAA while busy -> single done, Sum=0x0002; second request ignored.
- Start, then rst_n=0 for 1 cycle in the 2nd RUN cycle -> busy=0, Sum=0, cout=0, no done pulse. A fresh 0x0003+0x0004 then completes with Sum=0x0007.
- CHUNKED_ADD_SUB_EN defined: sub=1, A=0x0005, B=0x0007 -> Sum=0xFFFE, cout=0. sub=1, A=0x0007, B=0x0005 -> Sum=0x0002, cout=1.
